region_decoder: RTL and testbench

REGION_DECODER -- requirements
Module: region_decoder

---
 rtl/region_decoder.sv | 128 ++++++++++++
 tb/tb_region_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/region_decoder.sv
// Address region decoder with per-region wait states and CPU RDY stretching.
// Optional sticky unmapped-access latch enabled by defining REGION_FAULT_EN.
module region_decoder #(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 8,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {
    16'h8000, 16'h7FFF, 16'h7FF8, 16'h7FF7,
    16'h7FF6, 16'h7FF4, 16'h7FF0, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LAST = {
    16'hFFFF, 16'h7FFF, 16'h7FFB, 16'h7FF7,
    16'h7FF6, 16'h7FF5, 16'h7FF3, 16'h7FEF},
  parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT = 32'h0000_0002
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   strobe,
  output logic [NUM_REGIONS-1:0] cs,
  output logic                   hit,
  output logic                   rdy
`ifdef REGION_FAULT_EN
  ,
  input  logic                   fault_clr,
  output logic                   fault,
  output logic [ADDR_W-1:0]      fault_addr
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0]   cs_q, cs_d;
  logic                     hit_q, hit_d;

  logic [NUM_REGIONS-1:0]   dec_cs;
  logic                     dec_hit;
  logic [3:0]               dec_wait;
  logic                     accept;

  // Ascending scan with first-match latch gives lowest-index priority.
  always_comb begin
    dec_cs   = '0;
    dec_hit  = 1'b0;
    dec_wait = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (!dec_hit &&
          addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          addr <= REGION_LAST[i*ADDR_W +: ADDR_W]) begin
        dec_hit   = 1'b1;
        dec_cs[i] = 1'b1;
        dec_wait  = REGION_WAIT[i*4 +: 4];
      end
    end
  end

  assign rdy    = !(state_q == ACTIVE && cnt_q != 4'd0);
  assign accept = strobe && rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    hit_d   = hit_q;
    if (accept) begin
      state_d = ACTIVE;
      cs_d    = dec_cs;
      hit_d   = dec_hit;
      cnt_d   = dec_wait;
    end else if (state_q == ACTIVE && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
      cs_d    = '0;
      hit_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cs_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      hit_q   <= hit_d;
    end
  end

  assign cs  = cs_q;
  assign hit = hit_q;

`ifdef REGION_FAULT_EN
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

  // An unmapped access arriving with fault_clr re-latches instead of clearing.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (accept && !dec_hit && (!fault_q || fault_clr)) begin
      fault_d      = 1'b1;
      fault_addr_d = addr;
    end else if (fault_clr) begin
      fault_d      = 1'b0;
      fault_addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
`endif

endmodule

// File: tb/tb_region_decoder.sv
// Scoreboard bench for region_decoder: default instance plus an override instance
// (region 0 widened to 0x7FFF, region 7 shrunk to 0x8000-0xEFFF).
module tb_region_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic [15:0] addr = '0;
  logic        fault_clr = 1'b0;

  logic [7:0]  cs0, cs1;
  logic        hit0, hit1, rdy0, rdy1;
  logic        fault0, fault1;
  logic [15:0] faddr0, faddr1;

  always #5 clk = ~clk;

  region_decoder dut0 (
    .clk(clk), .rst(rst), .addr(addr), .strobe(strobe),
    .cs(cs0), .hit(hit0), .rdy(rdy0)
`ifdef REGION_FAULT_EN
    , .fault_clr(fault_clr), .fault(fault0), .fault_addr(faddr0)
`endif
  );

  region_decoder #(
    .REGION_LAST({16'hEFFF, 16'h7FFF, 16'h7FFB, 16'h7FF7,
                  16'h7FF6, 16'h7FF5, 16'h7FF3, 16'h7FFF})
  ) dut1 (
    .clk(clk), .rst(rst), .addr(addr), .strobe(strobe),
    .cs(cs1), .hit(hit1), .rdy(rdy1)
`ifdef REGION_FAULT_EN
    , .fault_clr(fault_clr), .fault(fault1), .fault_addr(faddr1)
`endif
  );

`ifndef REGION_FAULT_EN
  assign fault0 = 1'b0; assign faddr0 = '0;
  assign fault1 = 1'b0; assign faddr1 = '0;
`endif

  typedef struct {
    logic [7:0]  cs;
    logic        hit;
    logic        rdy;
    logic        fault;
    logic [15:0] faddr;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int tests = 0;
  int fails = 0;
  bit started = 0;
  bit done = 0;

  // Region tables as plain address ranges, one row per instance.
  int base_t[2][8] = '{'{32'h0000, 32'h7FF0, 32'h7FF4, 32'h7FF6, 32'h7FF7, 32'h7FF8, 32'h7FFF, 32'h8000},
                       '{32'h0000, 32'h7FF0, 32'h7FF4, 32'h7FF6, 32'h7FF7, 32'h7FF8, 32'h7FFF, 32'h8000}};
  int last_t[2][8] = '{'{32'h7FEF, 32'h7FF3, 32'h7FF5, 32'h7FF6, 32'h7FF7, 32'h7FFB, 32'h7FFF, 32'hFFFF},
                       '{32'h7FFF, 32'h7FF3, 32'h7FF5, 32'h7FF6, 32'h7FF7, 32'h7FFB, 32'h7FFF, 32'hEFFF}};
  int wait_t[8] = '{2, 0, 0, 0, 0, 0, 0, 0};

  // Model: an access occupies the bus for wait+1 cycles; rdy low while stall cycles remain.
  bit          m_busy[2];
  int          m_stall[2];
  logic [7:0]  m_cs[2];
  bit          m_hit[2];
  bit          m_fault[2];
  logic [15:0] m_faddr[2];

  function automatic int find_region(input int inst, input logic [15:0] a);
    for (int r = 0; r < 8; r++)
      if (int'(a) >= base_t[inst][r] && int'(a) <= last_t[inst][r]) return r;
    return -1;
  endfunction

  task automatic model_step(input int inst, input bit r, input bit s,
                            input logic [15:0] a, input bit c);
    exp_t e;
    int   reg_idx;
    bit   cpu_ready;
    bit   unmapped;
    cpu_ready = !(m_busy[inst] && m_stall[inst] > 0);
    if (r) begin
      m_busy[inst] = 0; m_stall[inst] = 0; m_cs[inst] = '0; m_hit[inst] = 0;
      m_fault[inst] = 0; m_faddr[inst] = '0;
    end else begin
      unmapped = 0;
      if (s && cpu_ready) begin
        reg_idx = find_region(inst, a);
        m_busy[inst] = 1;
        m_hit[inst]  = (reg_idx >= 0);
        m_cs[inst]   = (reg_idx >= 0) ? 8'(1 << reg_idx) : 8'h00;
        m_stall[inst] = (reg_idx >= 0) ? wait_t[reg_idx] : 0;
        unmapped = (reg_idx < 0);
      end else if (m_busy[inst] && m_stall[inst] > 0) begin
        m_stall[inst]--;
      end else begin
        m_busy[inst] = 0; m_cs[inst] = '0; m_hit[inst] = 0;
      end
      if (unmapped && (!m_fault[inst] || c)) begin
        m_fault[inst] = 1; m_faddr[inst] = a;
      end else if (c) begin
        m_fault[inst] = 0; m_faddr[inst] = '0;
      end
    end
    e.cs = m_cs[inst];
    e.hit = m_hit[inst];
    e.rdy = !(m_busy[inst] && m_stall[inst] > 0);
    e.fault = m_fault[inst];
    e.faddr = m_faddr[inst];
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drive(input bit r, input bit s, input logic [15:0] a, input bit c);
    @(negedge clk);
    rst = r; strobe = s; addr = a; fault_clr = c;
    model_step(0, r, s, a, c);
    model_step(1, r, s, a, c);
    started = 1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  task automatic compare(input int inst, input exp_t e, input logic [7:0] c,
                         input logic h, input logic rd, input logic f, input logic [15:0] fa);
    string p;
    p = (inst == 0) ? "dut0" : "dut1";
    chk({p, ".cs"},  {8'h00, c},  {8'h00, e.cs});
    chk({p, ".hit"}, {15'h0, h},  {15'h0, e.hit});
    chk({p, ".rdy"}, {15'h0, rd}, {15'h0, e.rdy});
`ifdef REGION_FAULT_EN
    chk({p, ".fault"}, {15'h0, f}, {15'h0, e.fault});
    chk({p, ".fault_addr"}, fa, e.faddr);
`endif
  endtask

  // Monitor: DUT presents a response every cycle; sample 2 time units after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (started && !done) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
        end else begin
          e = q0.pop_front(); compare(0, e, cs0, hit0, rdy0, fault0, faddr0);
          e = q1.pop_front(); compare(1, e, cs1, hit1, rdy1, fault1, faddr1);
        end
      end
    end
  end

  function automatic logic [15:0] pick_addr();
    logic [15:0] edges[8] = '{16'h0000, 16'h7FEF, 16'h7FF0, 16'h7FFF,
                              16'h8000, 16'hEFFF, 16'hF000, 16'hFFFF};
    case ($urandom_range(0, 3))
      0: return 16'($urandom);
      1: return 16'h7FE8 + 16'($urandom_range(0, 31));
      2: return edges[$urandom_range(0, 7)];
      default: return 16'hE000 + 16'($urandom_range(0, 16'h1FFF));
    endcase
  endfunction

  initial begin : stim
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_stall[i] = 0; m_cs[i] = '0; m_hit[i] = 0;
      m_fault[i] = 0; m_faddr[i] = '0;
    end
    // Reset, including a strobe that must be ignored.
    drive(1, 0, 16'h0000, 0);
    drive(1, 1, 16'h1234, 0);
    drive(0, 0, 16'h0000, 0);
    // Region 0 access with two wait states.
    drive(0, 1, 16'h1234, 0);
    repeat (4) drive(0, 0, 16'h0000, 0);
    // Zero-wait access followed back-to-back by another.
    drive(0, 1, 16'h7FF4, 0);
    drive(0, 1, 16'h9000, 0);
    repeat (2) drive(0, 0, 16'h0000, 0);
    // Overlap priority on the override instance; unmapped gap on the default one.
    drive(0, 1, 16'h7FF2, 0);
    repeat (3) drive(0, 0, 16'h0000, 0);
    drive(0, 1, 16'h7FFD, 0);
    drive(0, 0, 16'h0000, 0);
    // Reset during a wait aborts it; the next strobe decodes normally.
    drive(0, 1, 16'h1234, 0);
    drive(1, 0, 16'h0000, 0);
    drive(0, 1, 16'h2000, 0);
    repeat (4) drive(0, 0, 16'h0000, 0);
    // Unmapped accesses: first address sticks, clear, then clear racing a new fault.
    drive(0, 1, 16'hF000, 0);
    drive(0, 0, 16'h0000, 0);
    drive(0, 1, 16'hF100, 0);
    drive(0, 0, 16'h0000, 0);
    drive(0, 0, 16'h0000, 1);
    drive(0, 0, 16'h0000, 0);
    drive(0, 1, 16'hF200, 0);
    drive(0, 1, 16'hF300, 1);
    drive(0, 0, 16'h0000, 0);
    drive(0, 0, 16'h0000, 1);
    // Strobe held high through a wait: one access, next accepted on cnt=0.
    repeat (6) drive(0, 1, 16'h1234, 0);
    repeat (2) drive(0, 0, 16'h0000, 0);
    // Randomized traffic.
    for (int n = 0; n < 3000; n++)
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), pick_addr(),
            ($urandom_range(0, 15) == 0));
    drive(0, 0, 16'h0000, 0);
    @(posedge clk);
    #3;
    done = 1;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
